// File: rtl/spike_rate_encoder_pkg.sv
// rtl/spike_rate_encoder_pkg.sv - shared neuromorphic types and constants
package spike_rate_encoder_pkg;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_RUN  = 2'd1,
        ENC_DONE = 2'd2
    } enc_state_t;

    localparam int DEF_INT_W = 8;

    // Cycle counter covers WINDOW_LEN up to 256; spike counter saturates at 511.
    localparam int CYC_W = 9;
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/spike_phase_acc.sv
// rtl/spike_phase_acc.sv - phase accumulator exposing the carry of acc + addend
module spike_phase_acc
    import spike_rate_encoder_pkg::*;
#(
    parameter int INT_W = DEF_INT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [INT_W-1:0] addend_i,
    output logic             carry_o
);

    logic [INT_W-1:0] acc_q;
    logic [INT_W-1:0] acc_d;
    logic [INT_W:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, addend_i};
    assign carry_o = sum[INT_W];

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[INT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - rate-codes an intensity into a spike train over a fixed window
module spike_rate_encoder
    import spike_rate_encoder_pkg::*;
#(
    parameter int WINDOW_LEN = 256,
    parameter int INT_W      = DEF_INT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [INT_W-1:0] intensity,
    output logic             in_ready,
    input  logic             abort,
    output logic             spike_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] spike_count
);

    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW_LEN - 1);

    enc_state_t       state_q, state_d;
    logic [INT_W-1:0] intensity_q, intensity_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spike_q, spike_d;

    logic accept;
    logic run_step;
    logic carry;

    spike_phase_acc #(
        .INT_W (INT_W)
    ) u_phase_acc (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (accept),
        .en_i     (run_step),
        .addend_i (intensity_q),
        .carry_o  (carry)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        run_step = 1'b0;
        case (state_q)
            ENC_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ENC_RUN;
                end
            end
            ENC_RUN: begin
                // Abort wins over window completion and suppresses this cycle's step.
                if (abort) begin
                    state_d = ENC_IDLE;
                end else begin
                    run_step = 1'b1;
                    if (cyc_q == LAST_CYC) begin
                        state_d = ENC_DONE;
                    end
                end
            end
            ENC_DONE: begin
                state_d = ENC_IDLE;
            end
            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

    always_comb begin
        intensity_d = intensity_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        spike_d     = run_step & carry;
        if (accept) begin
            intensity_d = intensity;
            cyc_d       = '0;
            cnt_d       = '0;
        end else if (run_step) begin
            cyc_d = cyc_q + CYC_W'(1);
            if (carry && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENC_IDLE;
            intensity_q <= '0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            spike_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            intensity_q <= intensity_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            spike_q     <= spike_d;
        end
    end

    assign in_ready    = (state_q == ENC_IDLE);
    assign busy        = (state_q == ENC_RUN);
    assign done        = (state_q == ENC_DONE);
    assign spike_out   = spike_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - randomized self-checking bench for spike_rate_encoder
module tb_spike_rate_encoder;

    localparam int WL    = 256;
    localparam int INT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [INT_W-1:0] intensity;
    logic             in_ready;
    logic             abort;
    logic             spike_out;
    logic             busy;
    logic             done;
    logic [8:0]       spike_count;

    int n_vec = 0;
    int n_err = 0;

    spike_rate_encoder #(
        .WINDOW_LEN (WL),
        .INT_W      (INT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .intensity   (intensity),
        .in_ready    (in_ready),
        .abort       (abort),
        .spike_out   (spike_out),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_ph 0=idle 1=window running 2=window finished.
    // Spikes emitted after n steps are floor(n*I/2^INT_W); the per-step spike is the difference.
    int m_ph  = 0;
    int m_k   = 0;
    int m_I   = 0;
    int m_cnt = 0;
    int m_spk = 0;
    bit mv    = 1'b0;

    function automatic int fcnt(input int n, input int i);
        return (n * i) / (1 << INT_W);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_spk = 0; mv = 1'b1;
        end else begin
            case (m_ph)
                0: begin
                    m_spk = 0;
                    if (in_valid) begin
                        m_I = int'(intensity); m_k = 0; m_cnt = 0; m_ph = 1;
                    end
                end
                1: begin
                    if (abort) begin
                        m_ph = 0; m_spk = 0;
                    end else begin
                        m_spk = fcnt(m_k + 1, m_I) - fcnt(m_k, m_I);
                        m_k++;
                        m_cnt = (fcnt(m_k, m_I) > 511) ? 511 : fcnt(m_k, m_I);
                        if (m_k == WL) m_ph = 2;
                    end
                end
                default: begin
                    m_ph = 0; m_spk = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            check("in_ready",    in_ready,    m_ph == 0);
            check("busy",        busy,        m_ph == 1);
            check("done",        done,        m_ph == 2);
            check("spike_out",   spike_out,   m_spk);
            check("spike_count", spike_count, m_cnt);
        end
    end

    // Entered and left at negedge+1 with the DUT in IDLE.
    task automatic run_window(input int i_val, input int abort_at, input int vpulse_at,
                              input int rst_at, input bit noise,
                              output int spikes, output int dones, output int cnt_done,
                              output int first, output int last_c);
        spikes = 0; dones = 0; cnt_done = -1; first = -1; last_c = -1;
        in_valid  = 1'b1;
        intensity = INT_W'(i_val);
        abort     = 1'($urandom_range(0, 1));
        rst       = 1'b0;
        @(negedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        for (int c = 0; c < WL + 20; c++) begin
            if (!busy && !done) begin
                last_c = c;
                break;
            end
            if (spike_out) begin
                spikes++;
                if (first < 0) first = c;
            end
            if (done) begin
                dones++;
                cnt_done = int'(spike_count);
            end
            rst       = (c == rst_at);
            abort     = (c == abort_at) || (done && ($urandom_range(0, 1) == 1));
            in_valid  = (c == vpulse_at) || (noise && ($urandom_range(0, 7) == 0));
            intensity = INT_W'($urandom);
            @(negedge clk); #1;
        end
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
        check("window_terminates", last_c >= 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            in_valid = 1'b0;
            abort    = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        int sp, dn, cd, fs, lc, iv, ab;
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; intensity = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",    in_ready,    1);
        check("rst_busy",        busy,        0);
        check("rst_done",        done,        0);
        check("rst_spike_out",   spike_out,   0);
        check("rst_spike_count", spike_count, 0);
        rst = 1'b0;
        idle_cycles(2);

        run_window(128, -1, -1, -1, 1'b1, sp, dn, cd, fs, lc);
        check("i128_spikes", sp, 128);
        check("i128_first",  fs, 2);
        check("i128_dones",  dn, 1);
        check("i128_count",  cd, 128);

        run_window(0, -1, -1, -1, 1'b1, sp, dn, cd, fs, lc);
        check("i0_spikes", sp, 0);
        check("i0_dones",  dn, 1);
        check("i0_count",  cd, 0);

        run_window(255, -1, -1, -1, 1'b1, sp, dn, cd, fs, lc);
        check("i255_spikes", sp, 255);
        check("i255_first",  fs, 2);
        check("i255_count",  cd, 255);

        run_window(64, 10, -1, -1, 1'b0, sp, dn, cd, fs, lc);
        check("abort_dones",     dn,          0);
        check("abort_idle_at",   lc,          11);
        check("abort_in_ready",  in_ready,    1);
        check("abort_spike_out", spike_out,   0);
        check("abort_count",     spike_count, 2);
        idle_cycles(3);

        run_window(100, -1, 100, -1, 1'b0, sp, dn, cd, fs, lc);
        check("vpulse_spikes", sp, 100);
        check("vpulse_count",  cd, 100);

        run_window(200, -1, -1, 50, 1'b0, sp, dn, cd, fs, lc);
        check("rst_mid_dones",   dn,          0);
        check("rst_mid_idle_at", lc,          51);
        check("rst_mid_count",   spike_count, 0);
        check("rst_mid_ready",   in_ready,    1);
        run_window(37, -1, -1, -1, 1'b1, sp, dn, cd, fs, lc);
        check("after_rst_count", cd, 37);

        for (int w = 0; w < 20; w++) begin
            iv = $urandom_range(0, 255);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WL - 1) : -1;
            run_window(iv, ab, $urandom_range(0, WL - 1), -1, 1'b1, sp, dn, cd, fs, lc);
            if (ab < 0) begin
                check("rand_spikes", sp, iv);
                check("rand_count",  cd, iv);
                check("rand_dones",  dn, 1);
            end else begin
                check("rand_abort_dones", dn, 0);
            end
            idle_cycles($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
